// File: rtl/poly_note_player.sv
// rtl/poly_note_player.sv - polyphonic note player: per-voice timers and DDS, mixed to one signed sample
// Define POLY_NOTE_PLAYER_SATMIX_EN for a saturating full-width mix instead of the shift-scaled mix.

module frequency_rom #(
  parameter int NOTE_W = 6,
  parameter int DOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] addr,
  output logic [DOUT_W-1:0] dout
);
  logic [DOUT_W-1:0] dout_q, dout_d;

  // Increments for A1 (55 Hz) up to G#2 with a 22-bit accumulator at 48 kHz; octaves shift left.
  function automatic logic [DOUT_W-1:0] semitone_inc(input int semi);
    case (semi)
      0:       semitone_inc = DOUT_W'(4806);
      1:       semitone_inc = DOUT_W'(5092);
      2:       semitone_inc = DOUT_W'(5395);
      3:       semitone_inc = DOUT_W'(5715);
      4:       semitone_inc = DOUT_W'(6055);
      5:       semitone_inc = DOUT_W'(6415);
      6:       semitone_inc = DOUT_W'(6797);
      7:       semitone_inc = DOUT_W'(7201);
      8:       semitone_inc = DOUT_W'(7629);
      9:       semitone_inc = DOUT_W'(8083);
      10:      semitone_inc = DOUT_W'(8563);
      default: semitone_inc = DOUT_W'(9073);
    endcase
  endfunction

  always_comb begin : rom_lookup
    int idx;
    dout_d = '0;
    idx    = int'(addr) - 1;
    if (addr != '0) begin
      dout_d = semitone_inc(idx % 12) << (idx / 12);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

module dds #(
  parameter int PHASE_W  = 22,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [PHASE_W-1:0]  k,
  input  logic                sampling_pulse,
  output logic [SAMPLE_W-1:0] sample
);
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  // Sawtooth: the sample is the top of the advanced phase, read as two's complement.
  always_comb begin
    phase_d  = phase_q;
    sample_d = sample_q;
    if (clear) begin
      phase_d  = '0;
      sample_d = '0;
    end else if (sampling_pulse) begin
      phase_d  = phase_q + k;
      sample_d = phase_d[PHASE_W-1 -: SAMPLE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      sample_q <= '0;
    end else begin
      phase_q  <= phase_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;
endmodule

module poly_note_player #(
  parameter int VOICES   = 2,
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        play_enable,
  input  logic                                        load_new_note,
  input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] voice_sel,
  input  logic [NOTE_W-1:0]                           note_to_load,
  input  logic [DUR_W-1:0]                            duration_to_load,
  input  logic                                        beat,
  input  logic                                        sampling_pulse,
  output logic                                        note_done,
  output logic [VOICES-1:0]                           voice_busy,
  output logic [SAMPLE_W-1:0]                         sample,
  output logic                                        sample_ready
);
  localparam int VSEL_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int LOG2V   = $clog2(VOICES);
  localparam int SUM_W   = SAMPLE_W + LOG2V;
  localparam int PHASE_W = 22;
  localparam int ROM_W   = 20;

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} voice_state_e;

  voice_state_e        state_q [VOICES];
  voice_state_e        state_d [VOICES];
  logic [NOTE_W-1:0]   note_q  [VOICES];
  logic [NOTE_W-1:0]   note_d  [VOICES];
  logic [DUR_W-1:0]    cnt_q   [VOICES];
  logic [DUR_W-1:0]    cnt_d   [VOICES];
  logic [SAMPLE_W-1:0] dds_sample [VOICES];

  logic [VOICES-1:0]          load_hit;
  logic [VOICES-1:0]          busy;
  logic [VOICES*SAMPLE_W-1:0] contrib_flat;
  logic signed [SUM_W-1:0]    sum;
  logic [SAMPLE_W-1:0]        mix;

  logic                was_busy_q, was_busy_d;
  logic                note_done_q, note_done_d;
  logic                strobe_q, strobe_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_ready_q, sample_ready_d;

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    logic [ROM_W-1:0] rom_dout;

    // Out-of-range selects never match any channel index, so such loads fall away here.
    assign load_hit[v] = load_new_note && ({1'b0, voice_sel} == (VSEL_W + 1)'(v));

    frequency_rom #(.NOTE_W(NOTE_W), .DOUT_W(ROM_W)) u_rom (
      .clk  (clk),
      .rst  (reset),
      .addr (note_q[v]),
      .dout (rom_dout)
    );

    dds #(.PHASE_W(PHASE_W), .SAMPLE_W(SAMPLE_W)) u_dds (
      .clk            (clk),
      .rst            (reset),
      .clear          (!play_enable),
      .k              ({2'b00, rom_dout}),
      .sampling_pulse (sampling_pulse),
      .sample         (dds_sample[v])
    );
  end

  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      state_d[v] = state_q[v];
      note_d[v]  = note_q[v];
      cnt_d[v]   = cnt_q[v];
      if (load_hit[v]) begin
        state_d[v] = S_PLAY;
        note_d[v]  = note_to_load;
        cnt_d[v]   = (duration_to_load == '0) ? DUR_W'(1) : duration_to_load;
      end else if (state_q[v] == S_PLAY && beat && play_enable) begin
        if (cnt_q[v] == DUR_W'(1)) begin
          state_d[v] = S_IDLE;
        end else begin
          cnt_d[v] = cnt_q[v] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy         = '0;
    contrib_flat = '0;
    for (int v = 0; v < VOICES; v++) begin
      busy[v] = (state_q[v] == S_PLAY);
      if (busy[v] && note_q[v] != '0) begin
        contrib_flat[v*SAMPLE_W +: SAMPLE_W] = dds_sample[v];
      end
    end
  end

`ifdef POLY_NOTE_PLAYER_SATMIX_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(LOG2V + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(LOG2V + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};
`endif

  always_comb begin
    sum = '0;
    for (int v = 0; v < VOICES; v++) begin
      sum = sum + SUM_W'($signed(contrib_flat[v*SAMPLE_W +: SAMPLE_W]));
    end
`ifdef POLY_NOTE_PLAYER_SATMIX_EN
    if (sum > SAT_MAX) begin
      mix = SAMPLE_W'(SAT_MAX);
    end else if (sum < SAT_MIN) begin
      mix = SAMPLE_W'(SAT_MIN);
    end else begin
      mix = SAMPLE_W'(sum);
    end
`else
    mix = SAMPLE_W'(sum >>> LOG2V);
`endif
  end

  // strobe_q lines the mixer up with the cycle the channel DDS samples land.
  always_comb begin
    strobe_d       = sampling_pulse;
    was_busy_d     = |busy;
    note_done_d    = was_busy_q && (busy == '0);
    sample_d       = sample_q;
    sample_ready_d = 1'b0;
    if (strobe_q) begin
      sample_ready_d = 1'b1;
      sample_d       = play_enable ? mix : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        state_q[v] <= S_IDLE;
        note_q[v]  <= '0;
        cnt_q[v]   <= '0;
      end
      was_busy_q     <= 1'b0;
      note_done_q    <= 1'b0;
      strobe_q       <= 1'b0;
      sample_q       <= '0;
      sample_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      note_q         <= note_d;
      cnt_q          <= cnt_d;
      was_busy_q     <= was_busy_d;
      note_done_q    <= note_done_d;
      strobe_q       <= strobe_d;
      sample_q       <= sample_d;
      sample_ready_q <= sample_ready_d;
    end
  end

  assign voice_busy   = busy;
  assign note_done    = note_done_q;
  assign sample       = sample_q;
  assign sample_ready = sample_ready_q;
endmodule

// File: tb/tb_poly_note_player.sv
// tb/tb_poly_note_player.sv - directed and randomized checks of poly_note_player against a behavioural model
module tb_poly_note_player;
  localparam int VOICES    = 2;
  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 6;
  localparam int SAMPLE_W  = 16;
  localparam int SP_PERIOD = 8;
  localparam int BASE [12] = '{4806, 5092, 5395, 5715, 6055, 6415, 6797, 7201, 7629, 8083, 8563, 9073};

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                play_enable = 1'b1;
  logic                load_new_note = 1'b0;
  logic [0:0]          voice_sel = '0;
  logic [NOTE_W-1:0]   note_to_load = '0;
  logic [DUR_W-1:0]    duration_to_load = '0;
  logic                beat = 1'b0;
  logic                sampling_pulse = 1'b0;
  logic                note_done;
  logic [VOICES-1:0]   voice_busy;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_ready;

  always #5 clk = ~clk;

  poly_note_player #(.VOICES(VOICES), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .play_enable      (play_enable),
    .load_new_note    (load_new_note),
    .voice_sel        (voice_sel),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .beat             (beat),
    .sampling_pulse   (sampling_pulse),
    .note_done        (note_done),
    .voice_busy       (voice_busy),
    .sample           (sample),
    .sample_ready     (sample_ready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bcnt = 0;
  int beat_period = 0;
  int beats_seen = 0;
  int dones_seen = 0;
  int rdy_seen = 0;
  int nz_seen = 0;

  // Reference model: what each channel is doing, in note/beat terms.
  logic [VOICES-1:0] m_busy;
  int  m_note  [VOICES];
  int  m_left  [VOICES];
  int  m_k     [VOICES];
  int  m_phase [VOICES];
  int  m_dsamp [VOICES];
  int  m_fval  [VOICES];
  bit  m_strobe, m_ready, m_done, m_was_busy, m_force;
  int  m_sample;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int note_k(input int n);
    if (n == 0) return 0;
    return BASE[(n - 1) % 12] << ((n - 1) / 12);
  endfunction

  function automatic int to_s16(input int v);
    int t;
    t = v & 16'hFFFF;
    return (t >= 32768) ? t - 65536 : t;
  endfunction

  function automatic int mix_expect(input int s);
`ifdef POLY_NOTE_PLAYER_SATMIX_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    if (s >= 0) return s / VOICES;
    return -((-s + VOICES - 1) / VOICES);
`endif
  endfunction

  task automatic model_clear();
    m_busy = '0;
    for (int v = 0; v < VOICES; v++) begin
      m_note[v] = 0; m_left[v] = 0; m_k[v] = 0; m_phase[v] = 0; m_dsamp[v] = 0;
    end
    m_strobe = 0; m_ready = 0; m_done = 0; m_was_busy = 0; m_sample = 0;
  endtask

  task automatic model_step();
    int sum;
    bit any;
    if (reset) begin
      model_clear();
      return;
    end
    sum = 0;
    for (int v = 0; v < VOICES; v++) begin
      if (m_force) sum += m_fval[v];
      else if (m_busy[v] && m_note[v] != 0) sum += m_dsamp[v];
    end
    any        = |m_busy;
    m_done     = m_was_busy && !any;
    m_was_busy = any;
    m_ready    = m_strobe;
    if (m_strobe) m_sample = play_enable ? mix_expect(sum) : 0;
    m_strobe = sampling_pulse;
    for (int v = 0; v < VOICES; v++) begin
      if (!play_enable) begin
        m_phase[v] = 0;
        m_dsamp[v] = 0;
      end else if (sampling_pulse) begin
        m_phase[v] = (m_phase[v] + m_k[v]) % (1 << 22);
        m_dsamp[v] = to_s16(m_phase[v] >> 6);
      end
    end
    for (int v = 0; v < VOICES; v++) m_k[v] = note_k(m_note[v]);
    for (int v = 0; v < VOICES; v++) begin
      if (load_new_note && int'(voice_sel) == v) begin
        m_busy[v] = 1'b1;
        m_note[v] = int'(note_to_load);
        m_left[v] = (duration_to_load == 0) ? 1 : int'(duration_to_load);
      end else if (m_busy[v] && beat && play_enable) begin
        if (m_left[v] == 1) m_busy[v] = 1'b0;
        else m_left[v]--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (beat && play_enable) beats_seen++;
    model_step();
    #1;
    chk("cyc_busy", 32'(voice_busy), 32'(m_busy));
    chk("cyc_note_done", 32'(note_done), 32'(m_done));
    chk("cyc_sample_ready", 32'(sample_ready), 32'(m_ready));
    chk("cyc_sample", 32'($signed(sample)), m_sample);
    if (note_done) dones_seen++;
    if (sample_ready) begin
      rdy_seen++;
      if (sample != '0) nz_seen++;
    end
    cyc++;
    bcnt++;
    load_new_note  = 1'b0;
    sampling_pulse = (cyc % SP_PERIOD) == 0;
    beat           = (beat_period > 0) && ((bcnt % beat_period) == beat_period - 1);
  endtask

  task automatic restart_beats(input int period);
    beat_period = period;
    bcnt = 0;
    beat = 1'b0;
  endtask

  task automatic load(input int v, input int n, input int d);
    voice_sel        = 1'(v);
    note_to_load     = NOTE_W'(n);
    duration_to_load = DUR_W'(d);
    load_new_note    = 1'b1;
    tick();
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while (voice_busy != '0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fresh_sample();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_ready && n < 40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_clear();
    m_force = 0;
    tick();
    tick();
    chk("reset_busy", 32'(voice_busy), 0);
    chk("reset_sample", 32'(sample), 0);
    chk("reset_note_done", 32'(note_done), 0);
    chk("reset_sample_ready", 32'(sample_ready), 0);
    reset = 1'b0;
    repeat (4) tick();

    // Single note
    restart_beats(100);
    load(0, 10, 3);
    chk("single_busy", 32'(voice_busy), 1);
    beats_seen = 0; rdy_seen = 0; nz_seen = 0;
    run_until_idle(400);
    chk("single_idle", 32'(voice_busy), 0);
    chk("single_beats", beats_seen, 3);
    chk("single_sample_nonzero", 32'(nz_seen > 20), 1);
    tick();
    chk("single_done", 32'(note_done), 1);
    tick();
    chk("single_done_once", 32'(note_done), 0);

    // Chord
    restart_beats(20);
    dones_seen = 0; beats_seen = 0;
    load(0, $urandom_range(1, 63), 2);
    load(1, $urandom_range(1, 63), 4);
    chk("chord_busy11", 32'(voice_busy), 3);
    n = 0;
    while (voice_busy == 2'b11 && n < 200) begin tick(); n++; end
    chk("chord_busy10", 32'(voice_busy), 2);
    chk("chord_beats_a", beats_seen, 2);
    run_until_idle(200);
    chk("chord_idle", 32'(voice_busy), 0);
    chk("chord_beats_b", beats_seen, 4);
    repeat (3) tick();
    chk("chord_one_done", dones_seen, 1);

    // Rest and zero duration
    restart_beats(20);
    load(1, 0, 2);
    beats_seen = 0; rdy_seen = 0; nz_seen = 0;
    run_until_idle(200);
    chk("rest_beats", beats_seen, 2);
    chk("rest_silent", nz_seen, 0);
    restart_beats(20);
    load(0, $urandom_range(1, 63), 0);
    beats_seen = 0;
    run_until_idle(200);
    chk("dur0_beats", beats_seen, 1);

    // Pause mid-note
    restart_beats(20);
    load(0, 20, 6);
    beats_seen = 0;
    n = 0;
    while (beats_seen < 2 && n < 200) begin tick(); n++; end
    play_enable = 1'b0;
    rdy_seen = 0; nz_seen = 0;
    repeat (100) tick();
    chk("pause_busy", 32'(voice_busy), 1);
    chk("pause_silent", nz_seen, 0);
    chk("pause_ready_pulses", 32'(rdy_seen >= 12), 1);
    play_enable = 1'b1;
    beats_seen = 0;
    run_until_idle(300);
    chk("resume_beats", beats_seen, 4);
    repeat (2) tick();

    // Retrigger a busy channel
    restart_beats(20);
    load(0, 7, 3);
    beats_seen = 0;
    n = 0;
    while (beats_seen < 1 && n < 100) begin tick(); n++; end
    dones_seen = 0;
    load(0, 30, 3);
    beats_seen = 0;
    run_until_idle(300);
    chk("retrig_beats", beats_seen, 3);
    chk("retrig_no_early_done", dones_seen, 0);
    tick();
    chk("retrig_done", dones_seen, 1);

    // Randomized traffic checked cycle by cycle against the model
    restart_beats(10);
    for (int i = 0; i < 40; i++) begin
      load($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 4));
      repeat ($urandom_range(0, 40)) begin
        if ($urandom_range(0, 15) == 0) play_enable = ~play_enable;
        tick();
      end
    end
    play_enable = 1'b1;
    run_until_idle(500);
    chk("random_idle", 32'(voice_busy), 0);
    repeat (2) tick();

    // Mix arithmetic with forced channel contributions
    restart_beats(0);
    load(0, 12, 5);
    load(1, 24, 5);
    chk("mix_busy", 32'(voice_busy), 3);
    m_fval[0] = 32767; m_fval[1] = 32767; m_force = 1;
    force dut.contrib_flat = {16'sd32767, 16'sd32767};
    wait_fresh_sample();
    chk("mix_fullscale", 32'($signed(sample)), 32767);
    m_fval[0] = 20000; m_fval[1] = -30000;
    force dut.contrib_flat = {16'(-30000), 16'(20000)};
    wait_fresh_sample();
`ifdef POLY_NOTE_PLAYER_SATMIX_EN
    chk("mix_pair", 32'($signed(sample)), -10000);
`else
    chk("mix_pair", 32'($signed(sample)), -5000);
`endif
    release dut.contrib_flat;
    m_force = 0;

    // Asynchronous reset between edges while both channels are busy
    #3;
    reset = 1'b1;
    #1;
    chk("async_busy", 32'(voice_busy), 0);
    chk("async_sample", 32'(sample), 0);
    chk("async_note_done", 32'(note_done), 0);
    chk("async_sample_ready", 32'(sample_ready), 0);
    model_clear();
    repeat (2) tick();
    reset = 1'b0;
    dones_seen = 0;
    repeat (20) tick();
    chk("post_reset_no_done", dones_seen, 0);
    chk("post_reset_idle", 32'(voice_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poly_note_player.md
# poly_note_player

Polyphonic successor to the single-voice note player. Holds `VOICES` independent note channels, each with its own note latch, frequency lookup, DDS and beat-duration timer. Mixes all channels into one signed sample stream for the codec path. Sits between song_reader (note/duration/handshake) and the codec synchroniser (`sampling_pulse`), under mcu control (`play_enable`, `reset`).

## Interface
- `VOICES`, 2: number of channels; power of two, 1..8.
- `NOTE_W`, 6: note code width; frequency_rom address.
- `DUR_W`, 6: duration width, in beats.
- `SAMPLE_W`, 16: signed sample width.

- `clk` in 1: system clock (`sys_clk`).
- `reset` in 1: asynchronous, active-high; clears all state.
- `play_enable` in 1: high = play; low = pause.
- `load_new_note` in 1: one-cycle pulse; load `note_to_load`/`duration_to_load` into channel `voice_sel`.
- `voice_sel` in max(1,$clog2(VOICES)): target channel for the load.
- `note_to_load` in NOTE_W: note code; 0 = rest (silent, but timed).
- `duration_to_load` in DUR_W: length in beats.
- `beat` in 1: one-cycle timing tick (48 kHz base).
- `sampling_pulse` in 1: one-cycle request for a new sample.
- `note_done` out 1: one-cycle pulse when the last busy channel finishes.
- `voice_busy` out VOICES: per-channel playing flag.
- `sample` out SAMPLE_W: mixed signed sample.
- `sample_ready` out 1: one-cycle pulse; `sample` updated.

## Operation
- Per-channel FSM, states IDLE/PLAY; `voice_busy[v]` = (state==PLAY).
  - IDLE→PLAY: on `load_new_note` with `voice_sel==v`. Latches the note and sets `cnt = (duration==0) ? 1 : duration`.
  - PLAY: on `beat && play_enable`, if `cnt==1`, go to IDLE and raise an internal done; otherwise `cnt` decrements.
  - Load to a busy channel retriggers it: new note, new count, DDS phase not cleared, no done.
  - Load and expiry in the same cycle on the same channel: load wins, no done.
  - `voice_sel >= VOICES`: load ignored.
- Frequency: one frequency_rom per channel, addressed by the latched note. `k = {2'b00, dout}` feeds that channel's dds.
- Channel output:
  - Channel dds held in reset while `!play_enable || reset`.
  - Contributes its dds sample only when busy and note≠0; otherwise contributes 0.
- Mix:
  - Signed sum of all channel contributions, at width SAMPLE_W+log2(VOICES).
  - Default: arithmetic shift right by log2(VOICES), so there is no overflow.
- `note_done`: one-cycle pulse on the cycle after `voice_busy` goes from non-zero to all-zero. No pulse if a load in the same cycle keeps any channel busy.
- Pause (`play_enable` low):
  - Timers freeze.
  - Notes and counts are held.
  - Loads are still accepted.
  - Mix is forced to 0; `sample_ready` still pulses per `sampling_pulse`.
- `reset`:
  - All channels go to IDLE; notes and counts clear.
  - `sample`=0, `sample_ready`=0, `note_done`=0, `voice_busy`=0.

## Timing
- `load_new_note` at edge t: `voice_busy[v]` is high after t+1. ROM `k` is valid at t+2.
- `sampling_pulse` at cycle s:
  - Channel dds `new_sample_ready` follows existing dds latency (identical across channels).
  - Mixer registers on that pulse; `sample_ready` asserts the cycle after, for exactly one cycle.
  - `sample` then holds until the next update.
- Duration D≥1 loaded, `play_enable` high: the channel drops to IDLE on the D-th `beat` after the load. A beat in the load cycle itself is not counted.
- `note_done` is registered: one cycle after the final channel's IDLE transition.
- Reset asserted mid-note: outputs clear asynchronously. After release, the block idles until a new load.

## Configuration
- `POLY_NOTE_PLAYER_SATMIX_EN` defined: the mix is the full-width sum, saturated to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1], with no shift.
- Undefined: shift-scaled mix as above.
- All other behaviour is identical either way.

## Test plan
- Single note, VOICES=2:
  - Stimulus: load v0 note 10 dur 3, `play_enable`=1, beats every 100 cycles.
  - Required: `voice_busy`=01; it clears on the 3rd beat; `note_done` is a single pulse one cycle later; `sample` is nonzero while busy.
- Chord:
  - Stimulus: load v0 dur 2, then v1 dur 4, on consecutive cycles.
  - Required: `voice_busy` goes 11→10 after beat 2 and 10→00 after beat 4. Exactly one `note_done`, after beat 4.
- Rest and zero duration:
  - Note 0 dur 2: `sample`=0 throughout, busy for 2 beats.
  - Dur 0: busy for exactly 1 beat.
- Pause and retrigger:
  - Stimulus: drop `play_enable` mid-note for 5 beats.
  - Required: count frozen, `sample`=0, `sample_ready` still pulsing. On resume, the remaining beats complete.
  - Retrigger of a busy channel restarts its count with no `note_done`.
- Mix arithmetic:
  - Force both channels to full-scale +32767.
  - Default build: `sample` = 32767.
  - With `POLY_NOTE_PLAYER_SATMIX_EN`: `sample` = 32767 (saturated). A +20000/−30000 pair gives −5000 in the default build and −10000 with SATMIX.
- Async reset:
  - Stimulus: assert `reset` between clock edges while both channels are busy.
  - Required: `voice_busy`=0, `sample`=0, `note_done`=0 immediately, with no `note_done` pulse afterwards.
